lsu_unit: RTL

Parametrised load/store unit for the RV32I core. It replaces the fixed one-cycle load-stall scheme with a counted-latency load path, a request handshake, byte-lane store generation, load sign/zero extension, and a hazard scoreboard for one outstanding load. It sits between the ALU address output and the data port of the memory. Writeback goes to the register-file rd mux.

---
 rtl/lsu_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit: counted-latency loads, byte-lane stores, one-load scoreboard
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN
module lsu_unit #(
   parameter int ADDR_W  = 32,
   parameter int RD_W    = 5,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [RD_W-1:0]   req_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic [3:0]        mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic [RD_W-1:0]   wb_rd,
   output logic [31:0]       wb_data,
   output logic              pend_valid,
   output logic [RD_W-1:0]   pend_rd,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]      state;
   logic [2:0]      cnt;
   logic [RD_W-1:0] rd_q;
   logic [2:0]      size_q;
   logic [1:0]      off_q;
   logic [31:0]     data_q;
   logic            wb_en_q;

   logic        accept;
   logic        is_byte;
   logic        is_half;
   logic        misalign;
   logic        issue;
   logic [31:0] ext_data;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Codes 000/100 are byte, 001/101 halfword; every other code falls to word.
   assign is_byte   = (req_size[1:0] == 2'b00);
   assign is_half   = (req_size[1:0] == 2'b01);

   assign req_ready = !reset && ((state == S_IDLE) || (state == S_RESP));
   assign accept    = req_valid && req_ready;
   assign issue     = accept && !misalign;

   assign mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
   assign mem_re    = issue && !req_store;

   always_comb begin
      mem_we    = 4'b0000;
      mem_wdata = 32'h0;
      if (issue && req_store) begin
         if (is_byte) begin
            mem_we    = 4'b0001 << req_addr[1:0];
            mem_wdata = {4{req_wdata[7:0]}};
         end else if (is_half) begin
            mem_we    = req_addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{req_wdata[15:0]}};
         end else begin
            mem_we    = 4'b1111;
            mem_wdata = req_wdata;
         end
      end
   end

   always_comb begin
      lane_b   = mem_rdata[8*off_q +: 8];
      lane_h   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ext_data = mem_rdata;
      if (size_q[1:0] == 2'b00)
         ext_data = size_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      else if (size_q[1:0] == 2'b01)
         ext_data = size_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         rd_q    <= '0;
         size_q  <= 3'd0;
         off_q   <= 2'd0;
         data_q  <= 32'h0;
         wb_en_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_RESP: begin
               if (issue && !req_store) begin
                  rd_q    <= req_rd;
                  size_q  <= req_size;
                  off_q   <= req_addr[1:0];
                  cnt     <= 3'(MEM_LAT);
                  wb_en_q <= (req_rd != '0);
                  state   <= S_WAIT;
               end else begin
                  state   <= S_IDLE;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 3'd1;
               // Read data is valid on the edge that ends the last latency cycle.
               if (cnt <= 3'd1) begin
                  data_q <= ext_data;
                  state  <= S_RESP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign wb_valid   = (state == S_RESP) && wb_en_q;
   assign wb_rd      = rd_q;
   assign wb_data    = data_q;
   assign pend_valid = (state == S_WAIT);
   assign pend_rd    = rd_q;

`ifdef LSU_MISALIGN_TRAP_EN
   logic              fault_q;
   logic [ADDR_W-1:0] fault_addr_q;

   assign misalign = is_half ? req_addr[0] : (!is_byte && (req_addr[1:0] != 2'b00));

   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         fault_q      <= accept && misalign;
         fault_addr_q <= (accept && misalign) ? req_addr : '0;
      end
   end

   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;
`else
   assign misalign   = 1'b0;
   assign fault      = 1'b0;
   assign fault_addr = '0;
`endif

endmodule
